// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_write_arbiter_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    // Identifies which requester owned the most recent accept.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Busy scoreboard: one bit per register marking writes still in flight; x0 never busy.
// Latency: set/clear take effect at the next clock edge; read ports are combinational on state.
// Backpressure: none; set takes priority over clear on the same register in the same cycle.
module regfile_scoreboard
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N_REGS = NUM_REGS,
    parameter int IDX_W  = ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_vld_i,
    input  logic [IDX_W-1:0] set_idx_i,
    input  logic             clr_vld_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    input  logic [IDX_W-1:0] rd0_idx_i,
    output logic             rd0_busy_o,
    input  logic [IDX_W-1:0] rd1_idx_i,
    output logic             rd1_busy_o
);

    logic [N_REGS-1:0] busy_q;
    logic [N_REGS-1:0] busy_d;

    // Next busy vector: apply clear first so a same-cycle set on that register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_vld_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_vld_i && (set_idx_i != '0)) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register; synchronous reset clears every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd0_busy_o = busy_q[rd0_idx_i];
    assign rd1_busy_o = busy_q[rd1_idx_i];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Latency: accept in cycle N drives rf_we/rf_waddr/rf_wdata in cycle N+1.
// Backpressure: ready is combinational; both readies drop for one cooldown cycle after every accept.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    grant_e            last_grant_q, last_grant_d;
    logic              cooldown_q,   cooldown_d;
    logic              rf_we_q,      rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q,   rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q,   rf_wdata_d;

    logic              alu_acc;
    logic              mem_acc;
    logic              any_acc;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // Grant decision: idle during cooldown, lone requester wins, contention goes to the non-last grantee.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!cooldown_q) begin
            if (alu_valid && mem_valid) begin
                if (last_grant_q == GRANT_MEM) begin
                    alu_ready = 1'b1;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                alu_ready = alu_valid;
                mem_ready = mem_valid;
            end
        end
    end

    assign alu_acc  = alu_valid & alu_ready;
    assign mem_acc  = mem_valid & mem_ready;
    assign any_acc  = alu_acc | mem_acc;
    assign sel_rd   = alu_acc ? alu_rd   : mem_rd;
    assign sel_data = alu_acc ? alu_data : mem_data;

    // Next state: x0 accepts still rotate priority and trigger cooldown but never pulse rf_we.
    always_comb begin
        last_grant_d = last_grant_q;
        if (alu_acc) begin
            last_grant_d = GRANT_ALU;
        end else if (mem_acc) begin
            last_grant_d = GRANT_MEM;
        end
        cooldown_d = any_acc;
        rf_we_d    = any_acc && (sel_rd != '0);
        rf_waddr_d = rf_we_d ? sel_rd   : rf_waddr_q;
        rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
    end

    // Arbiter state and write-port output registers; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_MEM;
            cooldown_q   <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            cooldown_q   <= cooldown_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    regfile_scoreboard #(
        .N_REGS (NUM_REGS),
        .IDX_W  (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_vld_i  (alloc_valid),
        .set_idx_i  (alloc_rd),
        .clr_vld_i  (rf_we_q),
        .clr_idx_i  (rf_waddr_q),
        .rd0_idx_i  (rs1),
        .rd0_busy_o (rs1_busy),
        .rd1_idx_i  (rs2),
        .rd1_busy_o (rs2_busy)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: requesters hold rd/data while valid until accepted.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset       = 1'b1;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_data    = '0;
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        rs1         = '0;
        rs2         = '0;

        // ---- 1. reset state
        repeat (3) step();
        reset = 1'b0;
        settle();
        check("rst_we",    32'(rf_we),    32'h0);
        check("rst_waddr", 32'(rf_waddr), 32'h0);
        check("rst_wdata", rf_wdata,      32'h0);
        check("rst_ardy",  32'(alu_ready), 32'h0);
        for (int i = 0; i < 32; i++) begin
            step();
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            settle();
            check($sformatf("rst_busy1_%0d", i), 32'(rs1_busy), 32'h0);
            check($sformatf("rst_busy2_%0d", 31 - i), 32'(rs2_busy), 32'h0);
        end

        // ---- 2. single ALU write
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        settle();
        check("w1_c0_ardy", 32'(alu_ready), 32'h1);
        check("w1_c0_mrdy", 32'(mem_ready), 32'h0);
        check("w1_c0_we",   32'(rf_we),     32'h0);
        step();
        alu_valid = 1'b0;
        settle();
        check("w1_c1_we",    32'(rf_we),    32'h1);
        check("w1_c1_waddr", 32'(rf_waddr), 32'h5);
        check("w1_c1_wdata", rf_wdata,      32'hDEADBEEF);
        step();
        settle();
        check("w1_c2_we",    32'(rf_we),    32'h0);
        check("w1_c2_waddr", 32'(rf_waddr), 32'h5);
        check("w1_c2_wdata", rf_wdata,      32'hDEADBEEF);

        // ---- 3. contention from a fresh reset (ALU wins first)
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        settle();
        check("ct_c0_ardy", 32'(alu_ready), 32'h1);
        check("ct_c0_mrdy", 32'(mem_ready), 32'h0);
        check("ct_c0_we",   32'(rf_we),     32'h0);
        step(); settle();
        check("ct_c1_ardy",  32'(alu_ready), 32'h0);
        check("ct_c1_mrdy",  32'(mem_ready), 32'h0);
        check("ct_c1_we",    32'(rf_we),     32'h1);
        check("ct_c1_waddr", 32'(rf_waddr),  32'h1);
        check("ct_c1_wdata", rf_wdata,       32'h11);
        step(); settle();
        check("ct_c2_ardy", 32'(alu_ready), 32'h0);
        check("ct_c2_mrdy", 32'(mem_ready), 32'h1);
        check("ct_c2_we",   32'(rf_we),     32'h0);
        step(); settle();
        check("ct_c3_ardy",  32'(alu_ready), 32'h0);
        check("ct_c3_mrdy",  32'(mem_ready), 32'h0);
        check("ct_c3_we",    32'(rf_we),     32'h1);
        check("ct_c3_waddr", 32'(rf_waddr),  32'h2);
        check("ct_c3_wdata", rf_wdata,       32'h22);
        step(); settle();
        check("ct_c4_ardy", 32'(alu_ready), 32'h1);
        check("ct_c4_mrdy", 32'(mem_ready), 32'h0);
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        settle();
        check("ct_c5_we",    32'(rf_we),    32'h1);
        check("ct_c5_waddr", 32'(rf_waddr), 32'h1);
        check("ct_c5_wdata", rf_wdata,      32'h11);
        step(); settle();
        check("ct_c6_we", 32'(rf_we), 32'h0);

        // ---- 4. write to x0: accepted, no rf_we, cooldown still applies
        step();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF;
        settle();
        check("x0_c0_mrdy", 32'(mem_ready), 32'h1);
        step();
        mem_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        settle();
        check("x0_c1_we",    32'(rf_we),     32'h0);
        check("x0_c1_ardy",  32'(alu_ready), 32'h0);
        check("x0_c1_waddr", 32'(rf_waddr),  32'h1);
        check("x0_c1_wdata", rf_wdata,       32'h11);
        step(); settle();
        check("x0_c2_ardy", 32'(alu_ready), 32'h1);
        check("x0_c2_we",   32'(rf_we),     32'h0);
        step();
        alu_valid = 1'b0;
        settle();
        check("x0_c3_we",    32'(rf_we),    32'h1);
        check("x0_c3_waddr", 32'(rf_waddr), 32'h3);
        check("x0_c3_wdata", rf_wdata,      32'h33);
        step(); settle();
        check("x0_c4_we", 32'(rf_we), 32'h0);

        // ---- 5. scoreboard set / clear / set-wins
        step();
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        rs1 = 5'd7; rs2 = 5'd7;
        settle();
        check("sb_c0_nobypass", 32'(rs1_busy), 32'h0);
        step();
        alloc_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        settle();
        check("sb_c1_busy1", 32'(rs1_busy),  32'h1);
        check("sb_c1_busy2", 32'(rs2_busy),  32'h1);
        check("sb_c1_ardy",  32'(alu_ready), 32'h1);
        step();
        alu_valid = 1'b0;
        settle();
        check("sb_c2_we",    32'(rf_we),    32'h1);
        check("sb_c2_waddr", 32'(rf_waddr), 32'h7);
        check("sb_c2_busy",  32'(rs1_busy), 32'h1);
        step(); settle();
        check("sb_c3_clear", 32'(rs1_busy), 32'h0);
        check("sb_c3_we",    32'(rf_we),    32'h0);
        // re-allocate r7 in the very cycle its previous write lands
        step();
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
        settle();
        check("sw_c4_ardy", 32'(alu_ready), 32'h1);
        step();
        alu_valid = 1'b0;
        settle();
        check("sw_c5_we",   32'(rf_we),    32'h1);
        check("sw_c5_busy", 32'(rs1_busy), 32'h1);
        step();
        alloc_valid = 1'b0;
        settle();
        check("sw_c6_busy", 32'(rs1_busy), 32'h1);
        step(); settle();
        check("sw_c7_busy", 32'(rs1_busy), 32'h1);
        // allocating x0 never marks it busy
        step();
        alloc_valid = 1'b1; alloc_rd = 5'd0;
        rs2 = 5'd0;
        step();
        alloc_valid = 1'b0;
        settle();
        check("sb_x0_busy", 32'(rs2_busy), 32'h0);

        // ---- 6. reset mid-operation
        step();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        rs1 = 5'd9;
        settle();
        check("rm_c0_ardy", 32'(alu_ready), 32'h1);
        step();
        alu_valid = 1'b0;
        alloc_valid = 1'b0;
        reset = 1'b1;
        settle();
        check("rm_c1_we",    32'(rf_we),    32'h1);
        check("rm_c1_waddr", 32'(rf_waddr), 32'h9);
        check("rm_c1_busy",  32'(rs1_busy), 32'h1);
        step();
        reset = 1'b0;
        settle();
        check("rm_c2_we",    32'(rf_we),    32'h0);
        check("rm_c2_waddr", 32'(rf_waddr), 32'h0);
        check("rm_c2_wdata", rf_wdata,      32'h0);
        for (int i = 0; i < 32; i++) begin
            step();
            rs1 = 5'(i);
            settle();
            check($sformatf("rm_busy_%0d", i), 32'(rs1_busy), 32'h0);
        end
        // accept coinciding with reset is dropped
        step();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAA;
        reset = 1'b1;
        step();
        alu_valid = 1'b0;
        reset = 1'b0;
        settle();
        check("rd_drop_we", 32'(rf_we), 32'h0);
        step(); settle();
        check("rd_drop_we2", 32'(rf_we), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
